regfile_mp_bypass: RTL and testbench
====================================

// Module: regfile_mp_bypass
// PURPOSE
//  Parametrised multi-port integer register file for the multi-issue core.
//  N read ports, M write ports, x0 hardwired to zero, and deterministic same-address write priority.
//  Optional same-cycle write-to-read bypass and per-register busy scoreboard.
//  Sits between decode/issue (reads, busy check, allocate) and writeback (writes, busy release).
// PARAMETERS
//  NUM_RD      4   number of read ports
//  NUM_WR      2   number of write ports (index NUM_WR-1 = youngest lane)
//  DATA_WIDTH  32  register width
//  ADDR_WIDTH  5   address width; register count = 2**ADDR_WIDTH
//  BYPASS      1   1: read of reg being written this cycle returns new data; 0: returns old data
//  SB_EN       1   1: scoreboard present; 0: rd_busy tied 0, alloc ignored
// PORTS
//  clk         in   1                     clock
//  rst_n       in   1                     reset, synchronous, active-low
//  rd_addr     in   NUM_RD*ADDR_WIDTH     packed read addresses, port k at [k*AW +: AW]
//  rd_data     out  NUM_RD*DATA_WIDTH     packed read data (combinational)
//  rd_busy     out  NUM_RD                reg at rd_addr[k] has a pending producer (combinational)
//  wr_en       in   NUM_WR                write enables
//  wr_addr     in   NUM_WR*ADDR_WIDTH     packed write addresses
//  wr_data     in   NUM_WR*DATA_WIDTH     packed write data
//  alloc_en    in   NUM_WR                issue-side allocate: mark destination busy
//  alloc_addr  in   NUM_WR*ADDR_WIDTH     destinations being allocated
//  wr_collide  out  1                     registered: previous cycle had >=2 enabled writes to one nonzero addr
// BEHAVIOUR
//  - Reset (rst_n=0 at posedge): all regs <= 0, all busy bits <= 0, wr_collide <= 0.
//    rd_data reads 0 and rd_busy reads 0 from the first edge after reset.
//  - Write: on posedge, for each lane j with wr_en[j] and wr_addr[j]!=0, reg[wr_addr[j]] <= wr_data[j].
//    Lanes to distinct addresses all commit in the same cycle.
//  - Same-address write conflict: the highest-index enabled lane wins; lower lanes are dropped for that address.
//    wr_collide is 1 exactly one cycle later, otherwise 0.
//  - Address 0: writes ignored, reads return 0, never busy, never flagged as collision.
//  - Read latency 0 (combinational). BYPASS=1: if any enabled lane writes rd_addr[k] (!=0) this cycle,
//    rd_data[k] = winning lane's wr_data. BYPASS=0: rd_data[k] = stored value.
//  - Scoreboard (SB_EN=1), one busy bit per reg, updated on posedge:
//    set by alloc_en[j] && alloc_addr[j]!=0; cleared by wr_en[j] && wr_addr[j]!=0.
//    Same reg allocated and written in one cycle: set wins; the new producer is outstanding.
//    rd_busy[k] = busy[rd_addr[k]]. With BYPASS=1, a same-cycle clearing write masks it to 0
//    unless the same reg is also being allocated this cycle.
//  - Two alloc lanes to one address: single set, no error.
//  - Write to a non-busy reg is legal: data commits, busy stays 0.
//  - Reset asserted mid-operation overrides all same-cycle writes and allocates.
// STRUCTURE
//  - Shared package/define file: RF_DATA_WIDTH, RF_ADDR_WIDTH, RF_ZERO_REG constant, and a packed-slice macro
//    for the port k addr/data slice.
//  - Sub-module regfile_scoreboard: busy vector, set/clear priority, rd_busy lookup. Instantiated under SB_EN.
//  - Top level: storage array, per-address write-winner select (priority by lane index),
//    bypass muxes, and the collision detector flop.
// TESTING
//  1. Reset, then read x0..x31 on all ports -> all 0, rd_busy=0, wr_collide=0.
//  2. wr_en=2'b11, lane0 x5=0xAAAA, lane1 x5=0x5555 -> x5=0x5555 next cycle; wr_collide=1 one cycle later, then 0.
//  3. BYPASS=1: lane0 writes x7=0x1234 while rd_addr[2]=7 -> rd_data[2]=0x1234 same cycle.
//     BYPASS=0 -> old value that cycle, 0x1234 next cycle.
//  4. Write x0=0xFFFF on both lanes and alloc x0 -> x0 reads 0, rd_busy 0, wr_collide 0.
//  5. alloc x9; next cycle rd_busy(x9)=1; then write x9 and alloc x9 in the same cycle -> busy stays 1, x9 updated;
//     then write x9 alone -> busy 0 next cycle.
//  6. Write x3=0x77 and x4=0x88, then assert rst_n=0 in the same cycle as a write to x3=0x99
//     -> all regs 0, busy cleared, write discarded.

Source files
------------

// File: rtl/regfile_mp_bypass_pkg.sv
// Shared constants for the multi-port register file and its scoreboard.
// RF_SLICE(k, w) expands to the part-select of lane/port k in a packed bus of w-bit fields.
`ifndef REGFILE_MP_BYPASS_SLICE
`define REGFILE_MP_BYPASS_SLICE
`define RF_SLICE(k, w) ((k)*(w)) +: (w)
`endif

package regfile_mp_bypass_pkg;
    localparam int RF_DATA_WIDTH = 32;
    localparam int RF_ADDR_WIDTH = 5;
    localparam logic [RF_ADDR_WIDTH-1:0] RF_ZERO_REG = '0;
endpackage

// File: rtl/regfile_mp_bypass_scoreboard.sv
// Per-register busy tracking: allocate sets, writeback clears, set wins on overlap.
// rd_busy lookup optionally sees a same-cycle clearing write as already released.
module regfile_mp_bypass_scoreboard
    import regfile_mp_bypass_pkg::*;
#(
    parameter int NUM_RD     = 4,
    parameter int NUM_WR     = 2,
    parameter int ADDR_WIDTH = RF_ADDR_WIDTH,
    parameter int BYPASS     = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_RD*ADDR_WIDTH-1:0] rd_addr_i,
    input  logic [NUM_WR-1:0]            wr_en_i,
    input  logic [NUM_WR*ADDR_WIDTH-1:0] wr_addr_i,
    input  logic [NUM_WR-1:0]            alloc_en_i,
    input  logic [NUM_WR*ADDR_WIDTH-1:0] alloc_addr_i,
    output logic [NUM_RD-1:0]            rd_busy_o
);
    localparam int NUM_REGS = 2**ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] ZERO = ADDR_WIDTH'(RF_ZERO_REG);

    logic [NUM_REGS-1:0] busy_q, busy_d;
    logic [NUM_RD-1:0]   clr_hit, set_hit;

    // Next busy vector: clears first, then sets so a new producer stays outstanding
    always_comb begin
        busy_d = busy_q;
        for (int j = 0; j < NUM_WR; j++) begin
            if (wr_en_i[j] && wr_addr_i[`RF_SLICE(j, ADDR_WIDTH)] != ZERO)
                busy_d[wr_addr_i[`RF_SLICE(j, ADDR_WIDTH)]] = 1'b0;
        end
        for (int j = 0; j < NUM_WR; j++) begin
            if (alloc_en_i[j] && alloc_addr_i[`RF_SLICE(j, ADDR_WIDTH)] != ZERO)
                busy_d[alloc_addr_i[`RF_SLICE(j, ADDR_WIDTH)]] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // Busy register with synchronous reset
    always_ff @(posedge clk) begin
        if (!rst_n) busy_q <= '0;
        else        busy_q <= busy_d;
    end

    // Per read port: is the looked-up reg being released or re-allocated this cycle
    always_comb begin
        clr_hit = '0;
        set_hit = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            for (int j = 0; j < NUM_WR; j++) begin
                if (rd_addr_i[`RF_SLICE(k, ADDR_WIDTH)] != ZERO) begin
                    if (wr_en_i[j] && wr_addr_i[`RF_SLICE(j, ADDR_WIDTH)] == rd_addr_i[`RF_SLICE(k, ADDR_WIDTH)])
                        clr_hit[k] = 1'b1;
                    if (alloc_en_i[j] && alloc_addr_i[`RF_SLICE(j, ADDR_WIDTH)] == rd_addr_i[`RF_SLICE(k, ADDR_WIDTH)])
                        set_hit[k] = 1'b1;
                end
            end
        end
    end

    // Busy lookup, masked by a same-cycle release when bypass is enabled
    always_comb begin
        rd_busy_o = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            rd_busy_o[k] = busy_q[rd_addr_i[`RF_SLICE(k, ADDR_WIDTH)]];
            if (BYPASS != 0 && clr_hit[k] && !set_hit[k])
                rd_busy_o[k] = 1'b0;
        end
    end
endmodule

// File: rtl/regfile_mp_bypass.sv
// Multi-port integer register file: N combinational read ports, M write lanes
// (highest lane wins on same address), x0 hardwired to zero, optional write-to-read
// bypass, optional busy scoreboard and a registered same-address collision flag.
module regfile_mp_bypass
    import regfile_mp_bypass_pkg::*;
#(
    parameter int NUM_RD     = 4,
    parameter int NUM_WR     = 2,
    parameter int DATA_WIDTH = RF_DATA_WIDTH,
    parameter int ADDR_WIDTH = RF_ADDR_WIDTH,
    parameter int BYPASS     = 1,
    parameter int SB_EN      = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_RD*ADDR_WIDTH-1:0] rd_addr_i,
    output logic [NUM_RD*DATA_WIDTH-1:0] rd_data_o,
    output logic [NUM_RD-1:0]            rd_busy_o,
    input  logic [NUM_WR-1:0]            wr_en_i,
    input  logic [NUM_WR*ADDR_WIDTH-1:0] wr_addr_i,
    input  logic [NUM_WR*DATA_WIDTH-1:0] wr_data_i,
    input  logic [NUM_WR-1:0]            alloc_en_i,
    input  logic [NUM_WR*ADDR_WIDTH-1:0] alloc_addr_i,
    output logic                         wr_collide_o
);
    localparam int NUM_REGS = 2**ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] ZERO = ADDR_WIDTH'(RF_ZERO_REG);

    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
    logic                  wr_collide_q, wr_collide_d;

    // Storage next-state: lanes applied in ascending order so the youngest lane wins
    always_comb begin
        regs_d = regs_q;
        for (int j = 0; j < NUM_WR; j++) begin
            if (wr_en_i[j] && wr_addr_i[`RF_SLICE(j, ADDR_WIDTH)] != ZERO)
                regs_d[wr_addr_i[`RF_SLICE(j, ADDR_WIDTH)]] = wr_data_i[`RF_SLICE(j, DATA_WIDTH)];
        end
    end

    // Two or more enabled lanes targeting the same nonzero register
    always_comb begin
        wr_collide_d = 1'b0;
        for (int i = 0; i < NUM_WR; i++) begin
            for (int j = i + 1; j < NUM_WR; j++) begin
                if (wr_en_i[i] && wr_en_i[j] &&
                    wr_addr_i[`RF_SLICE(i, ADDR_WIDTH)] == wr_addr_i[`RF_SLICE(j, ADDR_WIDTH)] &&
                    wr_addr_i[`RF_SLICE(i, ADDR_WIDTH)] != ZERO)
                    wr_collide_d = 1'b1;
            end
        end
    end

    // Storage and collision flag, synchronous reset overrides same-cycle writes
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int r = 0; r < NUM_REGS; r++) regs_q[r] <= '0;
            wr_collide_q <= 1'b0;
        end else begin
            regs_q       <= regs_d;
            wr_collide_q <= wr_collide_d;
        end
    end

    // Read ports: stored value, overridden by the winning same-cycle write when bypassing
    always_comb begin
        rd_data_o = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            rd_data_o[`RF_SLICE(k, DATA_WIDTH)] = regs_q[rd_addr_i[`RF_SLICE(k, ADDR_WIDTH)]];
            if (BYPASS != 0) begin
                for (int j = 0; j < NUM_WR; j++) begin
                    if (wr_en_i[j] && rd_addr_i[`RF_SLICE(k, ADDR_WIDTH)] != ZERO &&
                        wr_addr_i[`RF_SLICE(j, ADDR_WIDTH)] == rd_addr_i[`RF_SLICE(k, ADDR_WIDTH)])
                        rd_data_o[`RF_SLICE(k, DATA_WIDTH)] = wr_data_i[`RF_SLICE(j, DATA_WIDTH)];
                end
            end
        end
    end

    assign wr_collide_o = wr_collide_q;

    generate
        if (SB_EN != 0) begin : g_sb
            regfile_mp_bypass_scoreboard #(
                .NUM_RD     (NUM_RD),
                .NUM_WR     (NUM_WR),
                .ADDR_WIDTH (ADDR_WIDTH),
                .BYPASS     (BYPASS)
            ) u_sb (
                .clk          (clk),
                .rst_n        (rst_n),
                .rd_addr_i    (rd_addr_i),
                .wr_en_i      (wr_en_i),
                .wr_addr_i    (wr_addr_i),
                .alloc_en_i   (alloc_en_i),
                .alloc_addr_i (alloc_addr_i),
                .rd_busy_o    (rd_busy_o)
            );
        end else begin : g_no_sb
            assign rd_busy_o = '0;
        end
    endgenerate
endmodule

// File: tb/tb_regfile_mp_bypass.sv
// Bench for regfile_mp_bypass: one bypassing instance and one non-bypassing
// instance share all inputs; expected read data flows through a queue.
module tb_regfile_mp_bypass;
    logic         clk;
    logic         rst_n;
    logic [19:0]  rd_addr;
    logic [127:0] rd_data, rd_data_nb;
    logic [3:0]   rd_busy, rd_busy_nb;
    logic [1:0]   wr_en;
    logic [9:0]   wr_addr;
    logic [63:0]  wr_data;
    logic [1:0]   alloc_en;
    logic [9:0]   alloc_addr;
    logic         wr_collide, wr_collide_nb;

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp;
    logic [31:0] mdl [32];

    regfile_mp_bypass #(.BYPASS(1), .SB_EN(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .rd_addr_i(rd_addr), .rd_data_o(rd_data),
        .rd_busy_o(rd_busy), .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
        .alloc_en_i(alloc_en), .alloc_addr_i(alloc_addr), .wr_collide_o(wr_collide)
    );

    regfile_mp_bypass #(.BYPASS(0), .SB_EN(1)) u_nb (
        .clk(clk), .rst_n(rst_n), .rd_addr_i(rd_addr), .rd_data_o(rd_data_nb),
        .rd_busy_o(rd_busy_nb), .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
        .alloc_en_i(alloc_en), .alloc_addr_i(alloc_addr), .wr_collide_o(wr_collide_nb)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] rdat(input int k);
        return rd_data[k*32 +: 32];
    endfunction

    function automatic logic [31:0] rdat_nb(input int k);
        return rd_data_nb[k*32 +: 32];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en      = '0;
        wr_addr    = '0;
        wr_data    = '0;
        alloc_en   = '0;
        alloc_addr = '0;
    endtask

    task automatic set_rd(input int k, input logic [4:0] a);
        rd_addr[k*5 +: 5] = a;
    endtask

    task automatic set_wr(input int j, input logic [4:0] a, input logic [31:0] d);
        wr_en[j]          = 1'b1;
        wr_addr[j*5 +: 5] = a;
        wr_data[j*32 +: 32] = d;
    endtask

    task automatic set_alloc(input int j, input logic [4:0] a);
        alloc_en[j]          = 1'b1;
        alloc_addr[j*5 +: 5] = a;
    endtask

    task automatic test_reset();
        idle();
        rd_addr = '0;
        rst_n = 1'b0;
        set_wr(0, 5'd5, 32'hDEAD_BEEF);
        set_alloc(1, 5'd6);
        tick();
        tick();
        rst_n = 1'b1;
        idle();
        tick();
        for (int a = 0; a < 32; a++) begin
            for (int k = 0; k < 4; k++) set_rd(k, 5'((a + k) % 32));
            #1;
            checks++;
            if (rd_data !== 128'h0) begin
                errors++;
                $display("FAIL reset_rd_data a=%0d: got %h expected 0", a, rd_data);
            end
            checks++;
            if (rd_busy !== 4'h0) begin
                errors++;
                $display("FAIL reset_rd_busy a=%0d: got %b expected 0000", a, rd_busy);
            end
        end
        checks++;
        if (wr_collide !== 1'b0) begin
            errors++;
            $display("FAIL reset_collide: got %b expected 0", wr_collide);
        end
    endtask

    task automatic test_write_priority();
        idle();
        set_wr(0, 5'd5, 32'h0000_AAAA);
        set_wr(1, 5'd5, 32'h0000_5555);
        exp_q.push_back(32'h0000_5555);
        tick();
        idle();
        set_rd(0, 5'd5);
        #1;
        exp = exp_q.pop_front();
        checks++;
        if (rdat(0) !== exp) begin
            errors++;
            $display("FAIL prio_x5: got %h expected %h", rdat(0), exp);
        end
        checks++;
        if (wr_collide !== 1'b1) begin
            errors++;
            $display("FAIL prio_collide_set: got %b expected 1", wr_collide);
        end
        checks++;
        if (rd_busy[0] !== 1'b0) begin
            errors++;
            $display("FAIL prio_nonbusy_write: got %b expected 0", rd_busy[0]);
        end
        tick();
        checks++;
        if (wr_collide !== 1'b0) begin
            errors++;
            $display("FAIL prio_collide_clear: got %b expected 0", wr_collide);
        end
        set_wr(0, 5'd10, 32'h1010_1010);
        set_wr(1, 5'd11, 32'h1111_1111);
        exp_q.push_back(32'h1010_1010);
        exp_q.push_back(32'h1111_1111);
        tick();
        idle();
        set_rd(0, 5'd10);
        set_rd(1, 5'd11);
        #1;
        for (int k = 0; k < 2; k++) begin
            exp = exp_q.pop_front();
            checks++;
            if (rdat(k) !== exp) begin
                errors++;
                $display("FAIL distinct_lane%0d: got %h expected %h", k, rdat(k), exp);
            end
        end
        checks++;
        if (wr_collide !== 1'b0) begin
            errors++;
            $display("FAIL distinct_collide: got %b expected 0", wr_collide);
        end
    endtask

    task automatic test_bypass();
        idle();
        set_rd(2, 5'd7);
        set_wr(0, 5'd7, 32'h0000_1234);
        exp_q.push_back(32'h0000_1234);
        #1;
        exp = exp_q.pop_front();
        checks++;
        if (rdat(2) !== exp) begin
            errors++;
            $display("FAIL bypass_same_cycle: got %h expected %h", rdat(2), exp);
        end
        checks++;
        if (rdat_nb(2) !== 32'h0) begin
            errors++;
            $display("FAIL nobypass_old: got %h expected 0", rdat_nb(2));
        end
        tick();
        idle();
        #1;
        checks++;
        if (rdat_nb(2) !== 32'h0000_1234) begin
            errors++;
            $display("FAIL nobypass_next: got %h expected 00001234", rdat_nb(2));
        end
        set_wr(0, 5'd7, 32'h0000_0001);
        set_wr(1, 5'd7, 32'h0000_0002);
        #1;
        checks++;
        if (rdat(2) !== 32'h0000_0002) begin
            errors++;
            $display("FAIL bypass_winner: got %h expected 00000002", rdat(2));
        end
        checks++;
        if (rdat_nb(2) !== 32'h0000_1234) begin
            errors++;
            $display("FAIL nobypass_winner_old: got %h expected 00001234", rdat_nb(2));
        end
        tick();
        idle();
        tick();
    endtask

    task automatic test_x0();
        idle();
        set_wr(0, 5'd0, 32'h0000_FFFF);
        set_wr(1, 5'd0, 32'h0000_FFFF);
        set_alloc(0, 5'd0);
        set_alloc(1, 5'd0);
        set_rd(0, 5'd0);
        #1;
        checks++;
        if (rdat(0) !== 32'h0) begin
            errors++;
            $display("FAIL x0_bypass: got %h expected 0", rdat(0));
        end
        tick();
        idle();
        #1;
        checks++;
        if (rdat(0) !== 32'h0) begin
            errors++;
            $display("FAIL x0_read: got %h expected 0", rdat(0));
        end
        checks++;
        if (rd_busy[0] !== 1'b0) begin
            errors++;
            $display("FAIL x0_busy: got %b expected 0", rd_busy[0]);
        end
        checks++;
        if (wr_collide !== 1'b0) begin
            errors++;
            $display("FAIL x0_collide: got %b expected 0", wr_collide);
        end
    endtask

    task automatic test_scoreboard();
        idle();
        set_alloc(0, 5'd9);
        tick();
        idle();
        set_rd(1, 5'd9);
        #1;
        checks++;
        if (rd_busy[1] !== 1'b1) begin
            errors++;
            $display("FAIL sb_alloc: got %b expected 1", rd_busy[1]);
        end
        set_wr(0, 5'd9, 32'h0000_BEEF);
        set_alloc(1, 5'd9);
        #1;
        checks++;
        if (rd_busy[1] !== 1'b1) begin
            errors++;
            $display("FAIL sb_realloc_comb: got %b expected 1", rd_busy[1]);
        end
        tick();
        idle();
        #1;
        checks++;
        if (rd_busy[1] !== 1'b1) begin
            errors++;
            $display("FAIL sb_set_wins: got %b expected 1", rd_busy[1]);
        end
        checks++;
        if (rdat(1) !== 32'h0000_BEEF) begin
            errors++;
            $display("FAIL sb_data_beef: got %h expected 0000beef", rdat(1));
        end
        set_wr(0, 5'd9, 32'h0000_CAFE);
        #1;
        checks++;
        if (rd_busy[1] !== 1'b0) begin
            errors++;
            $display("FAIL sb_bypass_clear: got %b expected 0", rd_busy[1]);
        end
        checks++;
        if (rd_busy_nb[1] !== 1'b1) begin
            errors++;
            $display("FAIL sb_nobypass_still: got %b expected 1", rd_busy_nb[1]);
        end
        tick();
        idle();
        #1;
        checks++;
        if (rd_busy_nb[1] !== 1'b0) begin
            errors++;
            $display("FAIL sb_release: got %b expected 0", rd_busy_nb[1]);
        end
        checks++;
        if (rdat(1) !== 32'h0000_CAFE) begin
            errors++;
            $display("FAIL sb_data_cafe: got %h expected 0000cafe", rdat(1));
        end
        set_alloc(0, 5'd12);
        set_alloc(1, 5'd12);
        tick();
        idle();
        set_rd(3, 5'd12);
        #1;
        checks++;
        if (rd_busy[3] !== 1'b1) begin
            errors++;
            $display("FAIL sb_dual_alloc: got %b expected 1", rd_busy[3]);
        end
        checks++;
        if (wr_collide !== 1'b0) begin
            errors++;
            $display("FAIL sb_dual_alloc_collide: got %b expected 0", wr_collide);
        end
    endtask

    task automatic test_reset_mid();
        idle();
        set_wr(0, 5'd3, 32'h0000_0077);
        set_wr(1, 5'd4, 32'h0000_0088);
        exp_q.push_back(32'h0000_0077);
        exp_q.push_back(32'h0000_0088);
        tick();
        idle();
        set_rd(0, 5'd3);
        set_rd(1, 5'd4);
        set_rd(2, 5'd9);
        set_rd(3, 5'd12);
        #1;
        for (int k = 0; k < 2; k++) begin
            exp = exp_q.pop_front();
            checks++;
            if (rdat(k) !== exp) begin
                errors++;
                $display("FAIL mid_pre_port%0d: got %h expected %h", k, rdat(k), exp);
            end
        end
        rst_n = 1'b0;
        set_wr(0, 5'd3, 32'h0000_0099);
        set_wr(1, 5'd3, 32'h0000_0055);
        set_alloc(0, 5'd4);
        tick();
        rst_n = 1'b1;
        idle();
        #1;
        checks++;
        if (rd_data !== 128'h0) begin
            errors++;
            $display("FAIL mid_rst_data: got %h expected 0", rd_data);
        end
        checks++;
        if (rd_busy !== 4'h0) begin
            errors++;
            $display("FAIL mid_rst_busy: got %b expected 0000", rd_busy);
        end
        checks++;
        if (wr_collide !== 1'b0) begin
            errors++;
            $display("FAIL mid_rst_collide: got %b expected 0", wr_collide);
        end
    endtask

    task automatic test_back_to_back();
        for (int r = 0; r < 32; r++) mdl[r] = '0;
        idle();
        for (int i = 0; i < 8; i++) begin
            logic [31:0] d0, d1;
            d0 = $urandom;
            d1 = $urandom;
            idle();
            set_wr(0, 5'(16 + i), d0);
            set_wr(1, 5'(1 + i), d1);
            mdl[16 + i] = d0;
            mdl[1 + i]  = d1;
            tick();
        end
        idle();
        for (int a = 0; a < 32; a += 4) begin
            for (int k = 0; k < 4; k++) begin
                set_rd(k, 5'(a + k));
                exp_q.push_back(mdl[a + k]);
            end
            #1;
            for (int k = 0; k < 4; k++) begin
                exp = exp_q.pop_front();
                checks++;
                if (rdat(k) !== exp) begin
                    errors++;
                    $display("FAIL b2b_x%0d: got %h expected %h", a + k, rdat(k), exp);
                end
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        rd_addr = '0;
        idle();
        test_reset();
        test_write_priority();
        test_bypass();
        test_x0();
        test_scoreboard();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
